// File: rtl/codec_timer_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// codec_timer_pkg
// Shared types and constants for the codec timer scheduler: FSM state
// encoding, the interval timer register map and control-register bits, and the
// reload-value helper.
// -----------------------------------------------------------------------------
package codec_timer_pkg;

    typedef logic [2:0]  tmr_addr_t;
    typedef logic [15:0] tmr_data_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTL,
        ST_WAIT_IRQ,
        ST_CLR_ST,
        ST_DONE,
        ST_STOP_CTL,
        ST_ABORTED
    } state_e;

    // Timer register map (16-bit registers).
    localparam tmr_addr_t TMR_STATUS   = 3'd0;
    localparam tmr_addr_t TMR_CONTROL  = 3'd1;
    localparam tmr_addr_t TMR_PERIOD_L = 3'd2;
    localparam tmr_addr_t TMR_PERIOD_H = 3'd3;

    // Control register bits.
    localparam tmr_data_t CTL_ITO   = 16'h0001;
    localparam tmr_data_t CTL_START = 16'h0004;
    localparam tmr_data_t CTL_STOP  = 16'h0008;

    // The timer counts load..0 inclusive, so an interval of P cycles needs
    // load = P-1. A zero period saturates instead of wrapping to 0xFFFF_FFFF.
    function automatic logic [31:0] reload_value(input logic [31:0] period);
        return (period == 32'd0) ? 32'd0 : period - 32'd1;
    endfunction

endpackage

// File: rtl/codec_timer_scheduler_if.sv
// -----------------------------------------------------------------------------
// codec_timer_if
// Avalon-MM write-only master link to the interval timer plus its interrupt.
//   address    : timer register address
//   chipselect : timer chipselect
//   write_n    : write strobe, active low
//   writedata  : 16-bit write data
//   irq        : timer interrupt (slave -> master)
// Modports: master (scheduler side), slave (timer side).
// -----------------------------------------------------------------------------
interface codec_timer_if;
    import codec_timer_pkg::*;

    tmr_addr_t address;
    logic      chipselect;
    logic      write_n;
    tmr_data_t writedata;
    logic      irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output irq
    );

endinterface

// File: rtl/codec_timer_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// codec_rr_arbiter
// Combinational round-robin pick: grants the first set request bit at or after
// ptr, wrapping past N_REQ-1 back to 0. The pointer lives in the parent.
//   req         : request vector
//   ptr         : highest-priority index this cycle
//   grant_valid : any request set
//   grant_id    : index of the winning request (0 when none)
// -----------------------------------------------------------------------------
module codec_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_id
);

    int idx;

    // NOTE: every variable assigned in an always_comb gets a default at the
    // top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/codec_timer_scheduler.sv
// -----------------------------------------------------------------------------
// codec_timer_scheduler
// Shares one Avalon-MM interval timer among N_REQ requesters. A round-robin
// winner has its interval programmed (period_l, period_h, control), the
// scheduler waits for the timer irq, clears the timeout status and pulses done
// to the winner. abort stops the timer and ends the sequence with aborted.
//   clk, reset_n : clock, synchronous active-low reset
//   req          : level request per client, held until its done pulse
//   req_period   : interval in clk cycles per client, slice i = [32i+31:32i]
//   abort        : cancels the interval in flight
//   done         : one-cycle pulse to the served client
//   aborted      : one-cycle pulse when an abort sequence completes
//   busy         : high from grant until done/aborted
//   busy_id      : index of the granted client, valid while busy
//   timer        : write master to the timer slave port, plus its irq
// -----------------------------------------------------------------------------
module codec_timer_scheduler
    import codec_timer_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   req_period,
    input  logic                  abort,
    output logic [N_REQ-1:0]      done,
    output logic                  aborted,
    output logic                  busy,
    output logic [ID_W-1:0]       busy_id,
    codec_timer_if.master         timer
);

    state_e            state, next_state;
    logic [ID_W-1:0]   rr_ptr;
    logic              grant_valid;
    logic [ID_W-1:0]   grant_id;
    logic [31:0]       load_q, load_d;
    logic              abort_flag;

    // Next values of the registered outputs.
    tmr_addr_t         addr_d;
    tmr_data_t         wdata_d;
    logic              cs_d, write_n_d;
    logic [N_REQ-1:0]  done_d;
    logic              aborted_d, busy_d;

    codec_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arbiter (
        .req         (req),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Reload value is captured in full at grant; later req_period changes do
    // not reach the interval in flight.
    always_comb begin
        load_d = load_q;
        if (state == ST_IDLE && grant_valid) begin
            load_d = reload_value(req_period[32*int'(grant_id) +: 32]);
        end
    end

    // -------------------------------------------------------------------------
    // State register and datapath
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            load_q     <= '0;
            busy_id    <= '0;
            abort_flag <= 1'b0;
        end else begin
            state  <= next_state;
            load_q <= load_d;
            if (state == ST_IDLE && grant_valid) begin
                busy_id <= grant_id;
                rr_ptr  <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
            if (state == ST_STOP_CTL) begin
                abort_flag <= 1'b1;
            end else if (state == ST_ABORTED) begin
                abort_flag <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:     if (grant_valid) next_state = ST_WR_PL;
            ST_WR_PL:    next_state = abort ? ST_STOP_CTL : ST_WR_PH;
            ST_WR_PH:    next_state = abort ? ST_STOP_CTL : ST_WR_CTL;
            // The control write has already gone out this cycle; STOP follows.
            ST_WR_CTL:   next_state = abort ? ST_STOP_CTL : ST_WAIT_IRQ;
            // irq beats a simultaneous abort: the interval completed normally.
            ST_WAIT_IRQ: begin
                if (timer.irq)  next_state = ST_CLR_ST;
                else if (abort) next_state = ST_STOP_CTL;
            end
            ST_CLR_ST:   next_state = abort_flag ? ST_ABORTED : ST_DONE;
            ST_DONE:     next_state = ST_IDLE;
            ST_STOP_CTL: next_state = ST_CLR_ST;
            ST_ABORTED:  next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: decoded from next_state and registered below, so each
    // write appears on the bus in the cycle its state is active.
    // -------------------------------------------------------------------------
    always_comb begin
        addr_d    = TMR_STATUS;
        wdata_d   = '0;
        cs_d      = 1'b0;
        write_n_d = 1'b1;
        done_d    = '0;
        aborted_d = 1'b0;
        busy_d    = 1'b0;
        unique case (next_state)
            ST_WR_PL: begin
                cs_d = 1'b1; write_n_d = 1'b0; busy_d = 1'b1;
                addr_d = TMR_PERIOD_L; wdata_d = load_d[15:0];
            end
            ST_WR_PH: begin
                cs_d = 1'b1; write_n_d = 1'b0; busy_d = 1'b1;
                addr_d = TMR_PERIOD_H; wdata_d = load_d[31:16];
            end
            ST_WR_CTL: begin
                cs_d = 1'b1; write_n_d = 1'b0; busy_d = 1'b1;
                addr_d = TMR_CONTROL; wdata_d = CTL_START | CTL_ITO;
            end
            ST_WAIT_IRQ: busy_d = 1'b1;
            ST_CLR_ST: begin
                cs_d = 1'b1; write_n_d = 1'b0; busy_d = 1'b1;
                addr_d = TMR_STATUS; wdata_d = '0;
            end
            ST_STOP_CTL: begin
                cs_d = 1'b1; write_n_d = 1'b0; busy_d = 1'b1;
                addr_d = TMR_CONTROL; wdata_d = CTL_STOP;
            end
            ST_DONE:    done_d[busy_id] = 1'b1;
            ST_ABORTED: aborted_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timer.address    <= TMR_STATUS;
            timer.writedata  <= '0;
            timer.chipselect <= 1'b0;
            timer.write_n    <= 1'b1;
            done             <= '0;
            aborted          <= 1'b0;
            busy             <= 1'b0;
        end else begin
            timer.address    <= addr_d;
            timer.writedata  <= wdata_d;
            timer.chipselect <= cs_d;
            timer.write_n    <= write_n_d;
            done             <= done_d;
            aborted          <= aborted_d;
            busy             <= busy_d;
        end
    end

endmodule
